gate_pipe: RTL

GATE_PIPE -- requirements
Module: gate_pipe

---
 rtl/gate_pipe_if.sv | 36 +++
 rtl/gate_pipe.sv | 98 +++++++++
 2 files changed

// File: rtl/gate_pipe_if.sv
// rtl/gate_pipe_if.sv - handshake bundle for gate_pipe
//
// Purpose: groups the operand input stream, the result output stream and
// the consumed-result counter of gate_pipe.
// Ports (design view, modport slave):
//   i_a          in   NINPUTS*WIDTH  packed operands, operand k = i_a[k*WIDTH +: WIDTH]
//   i_mode       in   3              bitwise operation select
//   i_in_valid   in   1              i_a/i_mode valid
//   o_in_ready   out  1              block accepts i_a/i_mode this cycle
//   o_y          out  WIDTH          result at the output stage
//   o_out_valid  out  1              o_y holds a valid result
//   i_out_ready  in   1              downstream consumes o_y this cycle
//   o_result_cnt out  16             results consumed since reset (wraps)
interface gate_pipe_if #(
    parameter int WIDTH   = 8,
    parameter int NINPUTS = 2
);
    logic [NINPUTS*WIDTH-1:0] i_a;
    logic [2:0]               i_mode;
    logic                     i_in_valid;
    logic                     o_in_ready;
    logic [WIDTH-1:0]         o_y;
    logic                     o_out_valid;
    logic                     i_out_ready;
    logic [15:0]              o_result_cnt;

    modport slave (
        input  i_a, i_mode, i_in_valid, i_out_ready,
        output o_in_ready, o_y, o_out_valid, o_result_cnt
    );

    modport master (
        output i_a, i_mode, i_in_valid, i_out_ready,
        input  o_in_ready, o_y, o_out_valid, o_result_cnt
    );
endinterface

// File: rtl/gate_pipe.sv
// rtl/gate_pipe.sv - elastic pipeline reducing NINPUTS operands with a bitwise gate
//
// Purpose: on each accepted transaction the NINPUTS operands are reduced
// bitwise according to i_mode, and the result travels through STAGES
// valid/data registers to the output. Stages advance independently so
// bubbles collapse under backpressure.
// Ports:
//   i_clk    in  1  clock, rising edge
//   i_rst_n  in  1  asynchronous active-low reset
//   bus      gate_pipe_if.slave  operand/result streams and result counter
module gate_pipe #(
    parameter int WIDTH   = 8,
    parameter int NINPUTS = 2,
    parameter int STAGES  = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    gate_pipe_if.slave   bus
);

    logic [STAGES-1:0] r_vld;
    logic [WIDTH-1:0]  r_dat [STAGES];
    logic [15:0]       r_cnt;

    logic [WIDTH-1:0]  w_and;
    logic [WIDTH-1:0]  w_or;
    logic [WIDTH-1:0]  w_xor;
    logic [WIDTH-1:0]  w_result;
    logic [STAGES-1:0] w_adv;

    // Result is formed from the operands at acceptance and only the
    // finished value is carried down the pipe.
    always_comb begin
        w_and = '1;
        w_or  = '0;
        w_xor = '0;
        for (int k = 0; k < NINPUTS; k++) begin
            w_and = w_and & bus.i_a[k*WIDTH +: WIDTH];
            w_or  = w_or  | bus.i_a[k*WIDTH +: WIDTH];
            w_xor = w_xor ^ bus.i_a[k*WIDTH +: WIDTH];
        end
        case (bus.i_mode)
            3'd0:    w_result = w_and;
            3'd1:    w_result = w_or;
            3'd2:    w_result = w_xor;
            3'd3:    w_result = ~w_and;
            3'd4:    w_result = ~w_or;
            3'd5:    w_result = ~w_xor;
            3'd6:    w_result = '0;
            default: w_result = '1;
        endcase
    end

    // Stage i can move when the output is being consumed or any stage from
    // i to the end has a hole to absorb the shift. Written as a flat scan
    // rather than a chain so no signal depends on another bit of itself.
    always_comb begin
        w_adv = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_adv[i] = bus.i_out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!r_vld[j]) begin
                    w_adv[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            r_cnt <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_vld[0] <= bus.i_in_valid;
                r_dat[0] <= w_result;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_adv[i]) begin
                    r_vld[i] <= r_vld[i-1];
                    r_dat[i] <= r_dat[i-1];
                end
            end
            if (r_vld[STAGES-1] && bus.i_out_ready) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign bus.o_in_ready   = w_adv[0];
    assign bus.o_y          = r_dat[STAGES-1];
    assign bus.o_out_valid  = r_vld[STAGES-1];
    assign bus.o_result_cnt = r_cnt;

endmodule
